// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART register command sequencer:
// FSM state encoding, response byte constants and command field layout.
package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_WRITE,
        ST_READ,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    localparam logic [7:0] ACK        = 8'h06;
    localparam logic [7:0] NAK        = 8'h15;
    localparam int         CMD_WR_BIT = 7;

    function automatic logic addr_valid(input logic [6:0] addr, input int num_regs);
        return {25'd0, addr} < num_regs;
    endfunction

endpackage

// File: rtl/uart_ctrl_timeout.sv
// Loadable down-counter that bounds how long a write command may wait for its data byte.
// Reloaded while clear is high; expire is high once the budget has been used up.
module uart_ctrl_timeout #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int             W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0]   LOAD = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/uart_reg_ctrl.sv
// Command sequencer between UART byte streams and a register file: parses write/read
// commands, strobes the register port and returns one ACK/NAK/data byte per command.
module uart_reg_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int CLK_HZ         = 50000000,
    parameter int NUM_REGS       = 16,
    parameter int TIMEOUT_CYCLES = CLK_HZ / 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       timeout,
    output logic [7:0] ovr_count
);

    state_t     state, state_next;
    logic [6:0] cmd_addr, cmd_addr_next;
    logic       cmd_ok, cmd_ok_next;
    logic       tx_valid_next, wr_en_next, rd_en_next, timeout_next;
    logic [7:0] tx_data_next, wdata_next, ovr_next;
    logic [6:0] addr_next;
    logic       expire;

    uart_ctrl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != ST_WAIT_DATA),
        .enable ((state == ST_WAIT_DATA) && !rx_valid),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cmd_addr  <= '0;
            cmd_ok    <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
            ovr_count <= '0;
        end else begin
            state     <= state_next;
            cmd_addr  <= cmd_addr_next;
            cmd_ok    <= cmd_ok_next;
            tx_valid  <= tx_valid_next;
            tx_data   <= tx_data_next;
            reg_wr_en <= wr_en_next;
            reg_rd_en <= rd_en_next;
            reg_addr  <= addr_next;
            reg_wdata <= wdata_next;
            busy      <= (state_next != ST_IDLE);
            timeout   <= timeout_next;
            ovr_count <= ovr_next;
        end
    end

    always_comb begin
        state_next    = state;
        cmd_addr_next = cmd_addr;
        cmd_ok_next   = cmd_ok;
        tx_valid_next = 1'b0;
        tx_data_next  = tx_data;
        wr_en_next    = 1'b0;
        rd_en_next    = 1'b0;
        addr_next     = reg_addr;
        wdata_next    = reg_wdata;
        timeout_next  = 1'b0;
        ovr_next      = ovr_count;

        case (state)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_data[CMD_WR_BIT]) begin
                        state_next    = ST_WAIT_DATA;
                        cmd_addr_next = rx_data[6:0];
                        cmd_ok_next   = addr_valid(rx_data[6:0], NUM_REGS);
                    end else if (addr_valid(rx_data[6:0], NUM_REGS)) begin
                        state_next = ST_READ;
                        rd_en_next = 1'b1;
                        addr_next  = rx_data[6:0];
                    end else begin
                        state_next    = ST_RESP;
                        tx_valid_next = 1'b1;
                        tx_data_next  = NAK;
                    end
                end
            end
            ST_WAIT_DATA: begin
                // A byte arriving on the expiry cycle still counts as the data byte.
                if (rx_valid) begin
                    if (cmd_ok) begin
                        state_next = ST_WRITE;
                        wr_en_next = 1'b1;
                        addr_next  = cmd_addr;
                        wdata_next = rx_data;
                    end else begin
                        state_next    = ST_RESP;
                        tx_valid_next = 1'b1;
                        tx_data_next  = NAK;
                    end
                end else if (expire) begin
                    state_next   = ST_IDLE;
                    timeout_next = 1'b1;
                end
            end
            ST_WRITE: begin
                state_next    = ST_RESP;
                tx_valid_next = 1'b1;
                tx_data_next  = ACK;
            end
            ST_READ: begin
                state_next = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                state_next    = ST_RESP;
                tx_valid_next = 1'b1;
                tx_data_next  = reg_rdata;
            end
            ST_RESP: begin
                tx_valid_next = 1'b1;
                if (tx_ready) begin
                    state_next    = ST_IDLE;
                    tx_valid_next = 1'b0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        if (rx_valid && (state != ST_IDLE) && (state != ST_WAIT_DATA) && (ovr_count != 8'hFF)) begin
            ovr_next = ovr_count + 8'd1;
        end
    end

endmodule
